// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the single-port RAM arbiter: FSM states and requester ids.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWN_CPU = 2'd1,
    OWN_IO  = 2'd2
  } arbStateT;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_IO  = 1'b1;

  // Wide enough for the largest legal MAX_BURST (15).
  localparam int BEAT_W = 4;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates one registered-read RAM port between a CPU and an IO/loader requester.
// Define MEM_ARB_RR_EN for round-robin contention; otherwise the CPU has fixed priority.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 14,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  input  logic              io_req,
  input  logic              io_we,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic [DATA_W-1:0] io_wdata,
  output logic              io_gnt,
  output logic              io_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_q
);

  localparam logic [BEAT_W-1:0] BurstLimit = BEAT_W'(MAX_BURST);

  arbStateT          state, stateNext;
  logic [BEAT_W-1:0] beatCnt, beatNext;
  logic              lastOwner, lastNext;
  logic              rdPending, rdOwner;
  logic              grantCpu, grantIo;
  logic              cpuWins;

  // Who takes the port when both request from IDLE or OWN_CPU.
  always_comb begin
`ifdef MEM_ARB_RR_EN
    cpuWins = (lastOwner == REQ_IO);
`else
    cpuWins = 1'b1;
`endif
  end

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned and infers a latch.
  always_comb begin
    stateNext = state;
    beatNext  = beatCnt;
    grantCpu  = 1'b0;
    grantIo   = 1'b0;
    if (!reset) begin
      unique case (state)
        IDLE, OWN_CPU: begin
          beatNext = '0;
          if (cpu_req && (!io_req || cpuWins)) begin
            grantCpu  = 1'b1;
            stateNext = OWN_CPU;
          end else if (io_req) begin
            grantIo   = 1'b1;
            stateNext = OWN_IO;
            // The entry grant is the first beat; an IO win over a waiting CPU is a single beat.
            beatNext  = cpu_req ? BurstLimit : BEAT_W'(1);
          end else begin
            stateNext = IDLE;
          end
        end
        OWN_IO: begin
          if (io_req && (!cpu_req || beatCnt < BurstLimit)) begin
            grantIo = 1'b1;
            if (beatCnt < BurstLimit) beatNext = beatCnt + BEAT_W'(1);
          end else if (cpu_req) begin
            grantCpu  = 1'b1;
            stateNext = OWN_CPU;
            beatNext  = '0;
          end else begin
            stateNext = IDLE;
            beatNext  = '0;
          end
        end
        default: begin
          stateNext = IDLE;
          beatNext  = '0;
        end
      endcase
    end
  end

  always_comb begin
    lastNext = lastOwner;
    if (grantCpu)     lastNext = REQ_CPU;
    else if (grantIo) lastNext = REQ_IO;
  end

  // The RAM sees the granted requester's fields; an idle port is driven to zero.
  always_comb begin
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    if (grantCpu) begin
      ram_addr  = cpu_addr;
      ram_we    = cpu_we;
      ram_wdata = cpu_wdata;
    end else if (grantIo) begin
      ram_addr  = io_addr;
      ram_we    = io_we;
      ram_wdata = io_wdata;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      beatCnt   <= '0;
      lastOwner <= REQ_IO;
      rdPending <= 1'b0;
      rdOwner   <= REQ_CPU;
    end else begin
      state     <= stateNext;
      beatCnt   <= beatNext;
      lastOwner <= lastNext;
      rdPending <= (grantCpu && !cpu_we) || (grantIo && !io_we);
      rdOwner   <= grantIo ? REQ_IO : REQ_CPU;
    end
  end

  assign cpu_gnt = grantCpu;
  assign io_gnt  = grantIo;

  // A read issued just before reset asserts must not surface while reset is held.
  assign cpu_rvalid = rdPending && (rdOwner == REQ_CPU) && !reset;
  assign io_rvalid  = rdPending && (rdOwner == REQ_IO) && !reset;
  assign rdata      = ram_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed vectors push expected grants and read returns,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_mem_port_arbiter;

  localparam int gNone = 0;
  localparam int gCpu  = 1;
  localparam int gIo   = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [13:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic        io_req = 1'b0, io_we = 1'b0;
  logic [13:0] io_addr = '0;
  logic [31:0] io_wdata = '0;
  logic        cpu_gnt, cpu_rvalid, io_gnt, io_rvalid, ram_we;
  logic [31:0] rdata, ram_wdata, ram_q;
  logic [13:0] ram_addr;

  mem_port_arbiter #(.ADDR_W(14), .DATA_W(32), .MAX_BURST(4)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
    .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_gnt(io_gnt), .io_rvalid(io_rvalid),
    .rdata(rdata), .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_q(ram_q)
  );

  always #5 clock = ~clock;

  // Registered-read RAM in the environment; shadow tracks what the bench expects it to hold.
  logic [31:0] mem    [0:511];
  logic [31:0] shadow [0:511];
  initial begin
    for (int i = 0; i < 512; i++) begin
      mem[i]    = 32'hA000_0000 | 32'(i);
      shadow[i] = 32'hA000_0000 | 32'(i);
    end
  end
  always @(posedge clock) begin
    if (ram_we) mem[ram_addr[8:0]] <= ram_wdata;
    ram_q <= mem[ram_addr[8:0]];
  end

  typedef enum {GntCpu, GntIo, RvCpu, RvIo} evKindT;
  typedef struct {
    evKindT      kind;
    logic [13:0] addr;
    logic        we;
    logic [31:0] data;
  } evT;

  evT sb[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expectEv(input evKindT kind);
    evT e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_%s actual=asserted required=none at %0t", kind.name(), $time);
    end else begin
      e = sb.pop_front();
      check("event_kind", 64'(kind), 64'(e.kind));
      if (kind == GntCpu || kind == GntIo) begin
        check("ram_addr", 64'(ram_addr), 64'(e.addr));
        check("ram_we", 64'(ram_we), 64'(e.we));
        check("ram_wdata", 64'(ram_wdata), 64'(e.data));
      end else begin
        check("rdata", 64'(rdata), 64'(e.data));
      end
    end
  endtask

  // Monitor: rvalid first, then grant, matching the push order of the stimulus.
  always @(negedge clock) begin
    if (reset) begin
      check("reset_outputs", 64'({cpu_gnt, io_gnt, cpu_rvalid, io_rvalid, ram_we}), 64'd0);
      check("reset_ram_addr", 64'(ram_addr), 64'd0);
    end else begin
      check("gnt_exclusive", 64'(cpu_gnt & io_gnt), 64'd0);
      if (cpu_rvalid) expectEv(RvCpu);
      if (io_rvalid)  expectEv(RvIo);
      if (cpu_gnt)    expectEv(GntCpu);
      if (io_gnt)     expectEv(GntIo);
      if (!cpu_gnt && !io_gnt) begin
        check("idle_ram_we", 64'(ram_we), 64'd0);
        check("idle_ram_addr", 64'(ram_addr), 64'd0);
      end
    end
  end

  task automatic step(input logic rst, input logic cReq, input logic cWe, input logic [13:0] cAddr,
                      input logic iReq, input logic iWe, input logic [13:0] iAddr,
                      input int expG, input bit noRv);
    logic [31:0] cWd, iWd;
    @(posedge clock);
    #1;
    cWd       = 32'hC000_0000 | 32'(cAddr);
    iWd       = 32'hD000_0000 | 32'(iAddr);
    reset     = rst;
    cpu_req   = cReq;
    cpu_we    = cWe;
    cpu_addr  = cAddr;
    cpu_wdata = cWd;
    io_req    = iReq;
    io_we     = iWe;
    io_addr   = iAddr;
    io_wdata  = iWd;
    if (expG == gCpu) begin
      sb.push_back('{kind: GntCpu, addr: cAddr, we: cWe, data: cWd});
      if (cWe) shadow[cAddr[8:0]] = cWd;
      else if (!noRv) sb.push_back('{kind: RvCpu, addr: cAddr, we: 1'b0, data: shadow[cAddr[8:0]]});
    end else if (expG == gIo) begin
      sb.push_back('{kind: GntIo, addr: iAddr, we: iWe, data: iWd});
      if (iWe) shadow[iAddr[8:0]] = iWd;
      else if (!noRv) sb.push_back('{kind: RvIo, addr: iAddr, we: 1'b0, data: shadow[iAddr[8:0]]});
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 14'h0, 1'b0, 1'b0, 14'h0, gNone, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset with both requests high: everything must stay quiet.
    step(1'b1, 1'b1, 1'b0, 14'h010, 1'b1, 1'b0, 14'h100, gNone, 1'b0);
    step(1'b1, 1'b1, 1'b0, 14'h010, 1'b1, 1'b0, 14'h100, gNone, 1'b0);

    // Single CPU read from IDLE, then a CPU write with its readback.
    step(1'b0, 1'b1, 1'b0, 14'h010, 1'b0, 1'b0, 14'h0, gCpu, 1'b0);
    idle();
    step(1'b0, 1'b1, 1'b1, 14'h020, 1'b0, 1'b0, 14'h0, gCpu, 1'b0);
    step(1'b0, 1'b1, 1'b0, 14'h020, 1'b0, 1'b0, 14'h0, gCpu, 1'b0);
    idle();

    // Pipelined back-to-back CPU reads.
    for (int a = 0; a < 3; a++)
      step(1'b0, 1'b1, 1'b0, 14'(a), 1'b0, 1'b0, 14'h0, gCpu, 1'b0);
    idle();
    idle();

    // IO write burst with the CPU waiting from the second beat: four IO beats, then CPU.
    step(1'b0, 1'b0, 1'b0, 14'h0, 1'b1, 1'b1, 14'h100, gIo, 1'b0);
    for (int a = 1; a < 4; a++)
      step(1'b0, 1'b1, 1'b0, 14'h101, 1'b1, 1'b1, 14'(16'h100 + a), gIo, 1'b0);
    step(1'b0, 1'b1, 1'b0, 14'h101, 1'b1, 1'b1, 14'h104, gCpu, 1'b0);
    for (int a = 4; a < 8; a++)
      step(1'b0, 1'b0, 1'b0, 14'h0, 1'b1, 1'b1, 14'(16'h100 + a), gIo, 1'b0);
    idle();

    // Saturated beat count: a late CPU request wins on its first cycle.
    for (int a = 8; a < 14; a++)
      step(1'b0, 1'b0, 1'b0, 14'h0, 1'b1, 1'b1, 14'(16'h100 + a), gIo, 1'b0);
    step(1'b0, 1'b1, 1'b0, 14'h108, 1'b1, 1'b1, 14'h10E, gCpu, 1'b0);
    step(1'b0, 1'b0, 1'b0, 14'h0, 1'b1, 1'b1, 14'h10E, gIo, 1'b0);
    idle();

    // Both requesters held from IDLE.
`ifdef MEM_ARB_RR_EN
    step(1'b0, 1'b1, 1'b0, 14'h003, 1'b1, 1'b0, 14'h100, gCpu, 1'b0);
    step(1'b0, 1'b1, 1'b0, 14'h004, 1'b1, 1'b0, 14'h100, gIo, 1'b0);
    step(1'b0, 1'b1, 1'b0, 14'h004, 1'b1, 1'b0, 14'h101, gCpu, 1'b0);
    step(1'b0, 1'b1, 1'b0, 14'h005, 1'b1, 1'b0, 14'h101, gIo, 1'b0);
    step(1'b0, 1'b1, 1'b0, 14'h005, 1'b0, 1'b0, 14'h0, gCpu, 1'b0);
`else
    for (int a = 3; a < 7; a++)
      step(1'b0, 1'b1, 1'b0, 14'(a), 1'b1, 1'b0, 14'h100, gCpu, 1'b0);
    step(1'b0, 1'b0, 1'b0, 14'h0, 1'b1, 1'b0, 14'h100, gIo, 1'b0);
`endif
    idle();

    // Reset lands right after a read grant: the return is dropped, then IDLE grants at once.
    step(1'b0, 1'b1, 1'b0, 14'h007, 1'b0, 1'b0, 14'h0, gCpu, 1'b1);
    step(1'b1, 1'b1, 1'b0, 14'h007, 1'b0, 1'b0, 14'h0, gNone, 1'b0);
    step(1'b1, 1'b0, 1'b0, 14'h0, 1'b0, 1'b0, 14'h0, gNone, 1'b0);
    step(1'b0, 1'b1, 1'b0, 14'h008, 1'b0, 1'b0, 14'h0, gCpu, 1'b0);
    idle();
    idle();

    @(negedge clock);
    #1;
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
